// File: rtl/loop_stack_ctrl.sv
// rtl/loop_stack_ctrl.sv - LIFO loop-address stack controller over an external registered RAM
module loop_stack_ctrl #(
    parameter int unsigned i_addr_width   = 16,
    parameter int unsigned max_loop_depth = 32'h100,
    parameter int unsigned sp_width       = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [i_addr_width-1:0] cmd_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [i_addr_width-1:0] rsp_data,
    output logic                    error,
    output logic [sp_width:0]       depth,
    output logic                    empty,
    output logic                    full,
    output logic [sp_width-1:0]     ram_write_addr,
    output logic                    ram_write_en,
    output logic [i_addr_width-1:0] ram_write_data,
    output logic [sp_width-1:0]     ram_read_addr,
    input  logic [i_addr_width-1:0] ram_read_data
);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PEEK = 2'b10;

    localparam logic [sp_width:0]   MAX_DEPTH = (sp_width+1)'(max_loop_depth);
    localparam logic [sp_width:0]   DEPTH_ONE = (sp_width+1)'(1);
    localparam logic [sp_width-1:0] PTR_ONE   = sp_width'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [sp_width:0]       r_depth;
    logic [sp_width-1:0]     r_rd_addr;
    logic [i_addr_width-1:0] r_rsp_data;
    logic                    r_error;

    logic                    w_idle;
    logic                    w_accept;
    logic                    w_is_read_op;
    logic                    w_push_ok;
    logic                    w_read_ok;
    logic                    w_reject;
    logic [sp_width-1:0]     w_top_ptr;

    // Command classification; only IDLE accepts, so everything keys off w_idle.
    assign w_idle       = (r_state == S_IDLE);
    assign w_accept     = cmd_valid & w_idle;
    assign w_is_read_op = (cmd_op == OP_POP) | (cmd_op == OP_PEEK);
    assign w_push_ok    = w_accept & (cmd_op == OP_PUSH) & ~full;
    assign w_read_ok    = w_accept & w_is_read_op & ~empty;
    assign w_reject     = w_accept & ~w_push_ok & ~w_read_ok;
    // Top-of-stack slot; wraps to the last RAM word when depth equals the RAM size.
    assign w_top_ptr    = r_depth[sp_width-1:0] - PTR_ONE;

    assign depth    = r_depth;
    assign empty    = (r_depth == '0);
    assign full     = (r_depth == MAX_DEPTH);
    assign rsp_data = r_rsp_data;
    assign error    = r_error;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: a good pop/peek walks IDLE->WAIT->RESP, RESP holds until consumed.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_read_ok) w_next_state = S_WAIT;
            S_WAIT:  w_next_state = S_RESP;
            S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs: handshake flags from state, RAM write strobes straight from the accepted push.
    always_comb begin
        cmd_ready      = w_idle;
        rsp_valid      = (r_state == S_RESP);
        ram_write_en   = w_push_ok;
        ram_write_addr = r_depth[sp_width-1:0];
        ram_write_data = cmd_data;
        ram_read_addr  = w_idle ? w_top_ptr : r_rd_addr;
    end

    // Depth counter: push and pop are mutually exclusive, rejects leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_depth <= '0;
        end else if (w_push_ok) begin
            r_depth <= r_depth + DEPTH_ONE;
        end else if (w_read_ok && (cmd_op == OP_POP)) begin
            r_depth <= r_depth - DEPTH_ONE;
        end
    end

    // Read address is frozen at accept so WAIT/RESP keep pointing at the same word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr <= '0;
        end else if (w_read_ok) begin
            r_rd_addr <= w_top_ptr;
        end
    end

    // Capture RAM output at the WAIT->RESP edge and hold it through the stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data <= '0;
        end else if (r_state == S_WAIT) begin
            r_rsp_data <= ram_read_data;
        end
    end

    // One-cycle error pulse for any rejected command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_error <= 1'b0;
        end else begin
            r_error <= w_reject;
        end
    end

endmodule

// File: tb/tb_loop_stack_ctrl.sv
// tb/tb_loop_stack_ctrl.sv - directed self-checking bench for loop_stack_ctrl
module tb_loop_stack_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        error;
    logic [8:0]  depth;
    logic        empty;
    logic        full;
    logic [7:0]  ram_write_addr;
    logic        ram_write_en;
    logic [15:0] ram_write_data;
    logic [7:0]  ram_read_addr;
    logic [15:0] ram_read_data;

    int n_checks = 0;
    int n_fail   = 0;
    int q_depth  = 0;
    int rsp_valid_cycles = 0;

    logic [15:0] mem [0:255];

    loop_stack_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_data       (cmd_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .error          (error),
        .depth          (depth),
        .empty          (empty),
        .full           (full),
        .ram_write_addr (ram_write_addr),
        .ram_write_en   (ram_write_en),
        .ram_write_data (ram_write_data),
        .ram_read_addr  (ram_read_addr),
        .ram_read_data  (ram_read_data)
    );

    always #5 clk = ~clk;

    // Registered RAM: write at edge, read data appears one clock after address sampled.
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
        ram_read_data <= mem[ram_read_addr];
    end

    always @(posedge clk) begin
        if (rsp_valid) rsp_valid_cycles <= rsp_valid_cycles + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q_depth = 0;
    endtask

    task automatic do_push(input logic [15:0] val, input string tag);
        cmd_valid = 1'b1;
        cmd_op = 2'b00;
        cmd_data = val;
        #1;
        n_checks++;
        if (ram_write_en !== 1'b1 || ram_write_addr !== 8'(q_depth) || ram_write_data !== val) begin
            n_fail++;
            $display("FAIL %s push_write: got en=%b addr=%0h data=%0h need en=1 addr=%0h data=%0h",
                     tag, ram_write_en, ram_write_addr, ram_write_data, 8'(q_depth), val);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        q_depth++;
        n_checks++;
        if (depth !== 9'(q_depth) || error !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s push_depth: got depth=%0h err=%b rdy=%b need depth=%0h err=0 rdy=1",
                     tag, depth, error, cmd_ready, q_depth);
        end
    endtask

    task automatic do_read(input logic [1:0] op, input logic [15:0] exp, input string tag);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_data = 16'hDEAD;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || ram_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL %s read_accept: got rdy=%b wen=%b need rdy=1 wen=0", tag, cmd_ready, ram_write_en);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        if (op == 2'b01) q_depth--;
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || depth !== 9'(q_depth)) begin
            n_fail++;
            $display("FAIL %s read_wait: got vld=%b rdy=%b depth=%0h need vld=0 rdy=0 depth=%0h",
                     tag, rsp_valid, cmd_ready, depth, q_depth);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp) begin
            n_fail++;
            $display("FAIL %s read_resp: got vld=%b data=%0h need vld=1 data=%0h", tag, rsp_valid, rsp_data, exp);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s read_done: got vld=%b rdy=%b need vld=0 rdy=1", tag, rsp_valid, cmd_ready);
        end
    endtask

    task automatic do_reject(input logic [1:0] op, input string tag);
        int vld_before;
        vld_before = rsp_valid_cycles;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_data = 16'hA5A5;
        #1;
        n_checks++;
        if (ram_write_en !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL %s rej_accept: got wen=%b err=%b need wen=0 err=0", tag, ram_write_en, error);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++;
        if (error !== 1'b1 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || depth !== 9'(q_depth)) begin
            n_fail++;
            $display("FAIL %s rej_pulse: got err=%b vld=%b rdy=%b depth=%0h need err=1 vld=0 rdy=1 depth=%0h",
                     tag, error, rsp_valid, cmd_ready, depth, q_depth);
        end
        @(negedge clk);
        n_checks++;
        if (error !== 1'b0 || rsp_valid_cycles != vld_before) begin
            n_fail++;
            $display("FAIL %s rej_end: got err=%b rsp_cycles=%0d need err=0 rsp_cycles=%0d",
                     tag, error, rsp_valid_cycles, vld_before);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (depth !== 9'd0 || empty !== 1'b1 || full !== 1'b0 || rsp_valid !== 1'b0 ||
            error !== 1'b0 || cmd_ready !== 1'b1 || rsp_data !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: got depth=%0h empty=%b full=%b vld=%b err=%b rdy=%b data=%0h need 0 1 0 0 0 1 0",
                     depth, empty, full, rsp_valid, error, cmd_ready, rsp_data);
        end
    endtask

    task automatic test_lifo();
        apply_reset();
        do_push(16'h0010, "lifo");
        do_push(16'h0020, "lifo");
        do_push(16'h0030, "lifo");
        do_read(2'b01, 16'h0030, "lifo_pop1");
        do_read(2'b01, 16'h0020, "lifo_pop2");
        do_read(2'b01, 16'h0010, "lifo_pop3");
        n_checks++;
        if (depth !== 9'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL lifo_end: got depth=%0h empty=%b need depth=0 empty=1", depth, empty);
        end
    endtask

    task automatic test_peek();
        apply_reset();
        do_push(16'h1234, "peek");
        do_read(2'b10, 16'h1234, "peek_peek");
        do_read(2'b01, 16'h1234, "peek_pop");
        n_checks++;
        if (depth !== 9'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL peek_end: got depth=%0h empty=%b need depth=0 empty=1", depth, empty);
        end
    endtask

    task automatic test_errors();
        apply_reset();
        do_reject(2'b01, "pop_empty");
        do_reject(2'b10, "peek_empty");
        do_reject(2'b11, "op11_empty");
        do_push(16'h0777, "err");
        do_reject(2'b11, "op11_nonempty");
        do_read(2'b01, 16'h0777, "err_pop");
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 256; i++) do_push(16'(i), "fill");
        n_checks++;
        if (full !== 1'b1 || empty !== 1'b0 || depth !== 9'h100) begin
            n_fail++;
            $display("FAIL full_flags: got full=%b empty=%b depth=%0h need full=1 empty=0 depth=100",
                     full, empty, depth);
        end
        do_reject(2'b00, "push_full");
        do_read(2'b01, 16'h00FF, "full_pop");
        n_checks++;
        if (full !== 1'b0 || depth !== 9'h0FF) begin
            n_fail++;
            $display("FAIL full_after_pop: got full=%b depth=%0h need full=0 depth=ff", full, depth);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        do_push(16'hBEEF, "stall");
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = 2'b10;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF || cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got vld=%b data=%0h rdy=%b need vld=1 data=beef rdy=0",
                         k, rsp_valid, rsp_data, cmd_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || depth !== 9'd1) begin
            n_fail++;
            $display("FAIL stall_release: got vld=%b rdy=%b depth=%0h need vld=0 rdy=1 depth=1",
                     rsp_valid, cmd_ready, depth);
        end
    endtask

    task automatic test_reset_mid();
        int vld_before;
        apply_reset();
        do_push(16'h0101, "rmid");
        do_push(16'h0202, "rmid");
        vld_before = rsp_valid_cycles;
        cmd_valid = 1'b1;
        cmd_op = 2'b01;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || depth !== 9'd0 || empty !== 1'b1 || rsp_data !== 16'h0) begin
            n_fail++;
            $display("FAIL rmid_async: got vld=%b depth=%0h empty=%b data=%0h need vld=0 depth=0 empty=1 data=0",
                     rsp_valid, depth, empty, rsp_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        q_depth = 0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || rsp_valid_cycles != vld_before) begin
            n_fail++;
            $display("FAIL rmid_release: got rdy=%b rsp_cycles=%0d need rdy=1 rsp_cycles=%0d",
                     cmd_ready, rsp_valid_cycles, vld_before);
        end
        do_push(16'h0303, "rmid_first");
        do_read(2'b01, 16'h0303, "rmid_pop");
        n_checks++;
        if (rsp_valid_cycles != vld_before + 1) begin
            n_fail++;
            $display("FAIL rmid_resp_count: got %0d need %0d", rsp_valid_cycles, vld_before + 1);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        do_push(16'h00A1, "b2b");
        do_read(2'b01, 16'h00A1, "b2b_pop_after_push");
        do_push(16'h00B2, "b2b");
        do_push(16'h00C3, "b2b");
        do_read(2'b10, 16'h00C3, "b2b_peek");
        do_read(2'b01, 16'h00C3, "b2b_pop1");
        do_read(2'b01, 16'h00B2, "b2b_pop2");
        do_reject(2'b01, "b2b_pop_empty");
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_data = 16'h0;
        rsp_ready = 1'b1;
        test_reset();
        test_lifo();
        test_peek();
        test_errors();
        test_full();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
